// File: rtl/tmds_video_timing.sv
// tmds_video_timing: turns decoded TMDS channel words into a registered pixel
// stream with x/y, and measures the incoming video timing until it locks.
// Ports: hdmi_clk, reset (async, active-high); data_valid, sync_valid,
//   sync[1:0] = {vsync, hsync}, d0/d1/d2 = blue/green/red decoded bytes.
//   pix_valid, r, g, b, x, y = pixel of the previous cycle and its position;
//   frame_start = pulse on vsync rise; h_active, v_active = measured size;
//   h_total, v_total = measured totals; locked = timing stable.
// Optional macro TMDS_VIDEO_TIMING_TOTALS_EN: measure h_total/v_total and
//   include them in the lock comparison; otherwise both ports read 0.
module tmds_video_timing #(
   parameter int XW           = 12,
   parameter int YW           = 12,
   parameter int LOCK_FRAMES  = 2,
   parameter int TIMEOUT_BITS = 22
) (
   input  logic          hdmi_clk,
   input  logic          reset,
   input  logic          data_valid,
   input  logic          sync_valid,
   input  logic [1:0]    sync,
   input  logic [7:0]    d0,
   input  logic [7:0]    d1,
   input  logic [7:0]    d2,
   output logic          pix_valid,
   output logic [7:0]    r,
   output logic [7:0]    g,
   output logic [7:0]    b,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y,
   output logic          frame_start,
   output logic [XW-1:0] h_active,
   output logic [YW-1:0] v_active,
   output logic [XW-1:0] h_total,
   output logic [YW-1:0] v_total,
   output logic          locked
);

   typedef enum logic [1:0] {UNLOCKED, MEASURE, LOCKED} state_t;

   localparam logic [7:0] LF = 8'(LOCK_FRAMES);

   state_t                  state, state_n;
   logic                    hs_q, vs_q;
   logic                    hs_rise, vs_rise;
   logic [XW-1:0]           cx, first_w, first_w_h;
   logic [YW-1:0]           cy, cy_h;
   logic                    mism, mism_h;
   logic                    match, tot_ok;
   logic [7:0]              mc, mc_n;
   logic [TIMEOUT_BITS-1:0] wd;
   logic                    wd_exp;

   // Edges of the held sync levels; a non-control cycle never moves them.
   assign hs_rise = sync_valid & sync[0] & ~hs_q;
   assign vs_rise = sync_valid & sync[1] & ~vs_q;
   assign wd_exp  = &wd;

   // Line bookkeeping after any hsync edge this cycle, so a coincident
   // vsync edge sees the line that just closed.
   always_comb begin
      cy_h      = cy;
      first_w_h = first_w;
      mism_h    = mism;
      if (hs_rise && cx != '0) begin
         if (!(&cy)) cy_h = cy + 1'b1;
         if (cy == '0) first_w_h = cx;
         else if (cx != first_w) mism_h = 1'b1;
      end
   end

   // h_active/v_active still hold the previous frame's figures here.
   assign match = (first_w_h == h_active) && (cy_h == v_active)
                  && !mism_h && tot_ok;

   always_comb begin
      state_n = state;
      mc_n    = mc;
      if (vs_rise) begin
         unique case (state)
            UNLOCKED: begin
               state_n = MEASURE;
               mc_n    = '0;
            end
            MEASURE: begin
               mc_n = match ? mc + 1'b1 : '0;
               if (mc_n == LF) state_n = LOCKED;
            end
            LOCKED: begin
               if (!match) begin
                  state_n = MEASURE;
                  mc_n    = '0;
               end
            end
            default: begin
               state_n = UNLOCKED;
               mc_n    = '0;
            end
         endcase
      end else if (wd_exp) begin
         state_n = UNLOCKED;
         mc_n    = '0;
      end
   end

   always_ff @(posedge hdmi_clk or posedge reset) begin
      if (reset) begin
         state       <= UNLOCKED;
         mc          <= '0;
         hs_q        <= 1'b0;
         vs_q        <= 1'b0;
         cx          <= '0;
         cy          <= '0;
         first_w     <= '0;
         mism        <= 1'b0;
         wd          <= '0;
         pix_valid   <= 1'b0;
         r           <= '0;
         g           <= '0;
         b           <= '0;
         x           <= '0;
         y           <= '0;
         frame_start <= 1'b0;
         h_active    <= '0;
         v_active    <= '0;
         locked      <= 1'b0;
      end else begin
         if (sync_valid) begin
            hs_q <= sync[0];
            vs_q <= sync[1];
         end
         pix_valid   <= data_valid;
         r           <= d2;
         g           <= d1;
         b           <= d0;
         x           <= cx;
         y           <= cy;
         frame_start <= vs_rise;
         state       <= state_n;
         mc          <= mc_n;
         locked      <= (state_n == LOCKED);
         if (vs_rise) begin
            cx       <= '0;
            cy       <= '0;
            first_w  <= '0;
            mism     <= 1'b0;
            wd       <= '0;
            h_active <= first_w_h;
            v_active <= cy_h;
         end else begin
            if (hs_rise) cx <= '0;
            else if (data_valid && !(&cx)) cx <= cx + 1'b1;
            cy      <= cy_h;
            first_w <= first_w_h;
            mism    <= mism_h;
            if (!wd_exp) wd <= wd + 1'b1;
         end
      end
   end

`ifdef TMDS_VIDEO_TIMING_TOTALS_EN
   logic [XW-1:0] hcnt, ht_q, ht_h, ht_ref;
   logic [YW-1:0] vcnt, vcnt_h, vt_q;

   always_comb begin
      ht_h   = hs_rise ? hcnt : ht_q;
      vcnt_h = vcnt;
      if (hs_rise && !(&vcnt)) vcnt_h = vcnt + 1'b1;
   end

   assign tot_ok  = (ht_h == ht_ref) && (vcnt_h == vt_q);
   assign h_total = ht_q;
   assign v_total = vt_q;

   // hcnt counts the edge cycle itself, so it equals the hsync period.
   always_ff @(posedge hdmi_clk or posedge reset) begin
      if (reset) begin
         hcnt   <= '0;
         ht_q   <= '0;
         ht_ref <= '0;
         vcnt   <= '0;
         vt_q   <= '0;
      end else begin
         if (hs_rise) begin
            ht_q <= hcnt;
            hcnt <= {{(XW-1){1'b0}}, 1'b1};
         end else if (!(&hcnt)) begin
            hcnt <= hcnt + 1'b1;
         end
         if (vs_rise) begin
            vt_q   <= vcnt_h;
            vcnt   <= '0;
            ht_ref <= ht_h;
         end else begin
            vcnt <= vcnt_h;
         end
      end
   end
`else
   assign tot_ok  = 1'b1;
   assign h_total = '0;
   assign v_total = '0;
`endif

endmodule

// File: tb/tb_tmds_video_timing.sv
// tb_tmds_video_timing: random video frames against a frame-level model.
// Ports: none; drives tmds_video_timing and prints one summary line.
module tb_tmds_video_timing;

   localparam int XW = 12;
   localparam int YW = 12;
   localparam int LF = 2;
   localparam int TB = 12;

   logic          hdmi_clk = 1'b0;
   logic          reset = 1'b0;
   logic          data_valid = 1'b0;
   logic          sync_valid = 1'b0;
   logic [1:0]    sync = 2'b00;
   logic [7:0]    d0 = 8'h0, d1 = 8'h0, d2 = 8'h0;
   logic          pix_valid, frame_start, locked;
   logic [7:0]    r, g, b;
   logic [XW-1:0] x, h_active, h_total;
   logic [YW-1:0] y, v_active, v_total;

   tmds_video_timing #(
      .XW(XW), .YW(YW), .LOCK_FRAMES(LF), .TIMEOUT_BITS(TB)
   ) dut (
      .hdmi_clk(hdmi_clk), .reset(reset),
      .data_valid(data_valid), .sync_valid(sync_valid), .sync(sync),
      .d0(d0), .d1(d1), .d2(d2),
      .pix_valid(pix_valid), .r(r), .g(g), .b(b), .x(x), .y(y),
      .frame_start(frame_start),
      .h_active(h_active), .v_active(v_active),
      .h_total(h_total), .v_total(v_total), .locked(locked)
   );

   always #5 hdmi_clk = ~hdmi_clk;

   int total = 0;
   int bad = 0;

   // frame-level reference state
   int hact, vact, htot, vtot;
   int cur_h, cur_v;
   bit cur_m;
   int m_h, m_v, m_ht, m_vt;
   int streak;
   bit fresh;
   int ncyc, last_hs, hs_cnt, ht_exp, vt_exp;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step(input bit dv, input bit sv, input logic [1:0] sy,
                       input bit hs_e, input bit vs_e,
                       input int col, input int line);
      logic [7:0] p0, p1, p2;
      bit         mt;
      p0 = 8'($urandom);
      p1 = 8'($urandom);
      p2 = 8'($urandom);
      data_valid = dv;
      sync_valid = sv;
      sync       = sy;
      d0 = p0;
      d1 = p1;
      d2 = p2;
      @(posedge hdmi_clk);
      #1;
      ncyc++;
      if (hs_e) begin
         ht_exp  = ncyc - last_hs;
         last_hs = ncyc;
         hs_cnt++;
      end
      chk("pix_valid", 32'(pix_valid), 32'(dv));
      if (dv) begin
         chk("rgb", {8'h0, r, g, b}, {8'h0, p2, p1, p0});
         chk("x", 32'(x), 32'(col));
         chk("y", 32'(y), 32'(line));
      end
      chk("frame_start", 32'(frame_start), 32'(vs_e));
      if (vs_e) begin
         vt_exp = hs_cnt;
         hs_cnt = 0;
         mt = (cur_h == m_h) && (cur_v == m_v) && !cur_m;
`ifdef TMDS_VIDEO_TIMING_TOTALS_EN
         mt = mt && (ht_exp == m_ht) && (vt_exp == m_vt);
         chk("h_total", 32'(h_total), 32'(ht_exp));
         chk("v_total", 32'(v_total), 32'(vt_exp));
`endif
         // locked == the last LF frame-to-frame comparisons all matched,
         // counting only frames after the first edge since unlock
         if (fresh) begin
            fresh  = 1'b0;
            streak = 0;
         end else begin
            streak = mt ? streak + 1 : 0;
         end
         m_h  = cur_h;
         m_v  = cur_v;
         m_ht = ht_exp;
         m_vt = vt_exp;
         chk("h_active", 32'(h_active), 32'(cur_h));
         chk("v_active", 32'(v_active), 32'(cur_v));
         chk("locked", 32'(locked), 32'(streak >= LF));
      end
   endtask

   // Line: pixel slots 0..w-1, then control words; hsync high at
   // hact+2..hact+5. Mode 0 raises vsync at the start of blank line
   // vact+2; mode 1 raises it on the last active line's hsync edge.
   task automatic send_frame(input int bad_line, input bit mode1,
                             input int ab_l, input int ab_c);
      int  w;
      bit  hs, vs, hs_e, vs_e;
      cur_h = hact;
      cur_v = vact;
      cur_m = (bad_line >= 1) && (bad_line < vact);
      for (int l = 0; l < vtot; l++) begin
         for (int c = 0; c < htot; c++) begin
            if (l == ab_l && c == ab_c) return;
            w    = (l == bad_line) ? hact - 1 : hact;
            hs   = (c >= hact + 2) && (c < hact + 6);
            hs_e = (c == hact + 2);
            if (mode1) begin
               vs   = (l == vact - 1 && c >= hact + 2) ||
                      l == vact || l == vact + 1;
               vs_e = (l == vact - 1) && (c == hact + 2);
            end else begin
               vs   = (l == vact + 2) || (l == vact + 3);
               vs_e = (l == vact + 2) && (c == 0);
            end
            if (l < vact && c < w)
               step(1'b1, 1'b0, 2'($urandom), 1'b0, 1'b0, c, l);
            else
               step(1'b0, 1'b1, {vs, hs}, hs_e, vs_e, 0, 0);
         end
      end
   endtask

   task automatic new_params();
      hact = $urandom_range(24, 16);
      vact = $urandom_range(14, 8);
      htot = hact + $urandom_range(14, 8);
      vtot = vact + $urandom_range(9, 6);
   endtask

   task automatic do_reset();
      data_valid = 1'b0;
      sync_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_flags", {29'h0, pix_valid, frame_start, locked}, 32'h0);
      chk("rst_rgb", {8'h0, r, g, b}, 32'h0);
      chk("rst_xy", {8'h0, x, y}, 32'h0);
      chk("rst_act", {8'h0, h_active, v_active}, 32'h0);
      chk("rst_tot", {8'h0, h_total, v_total}, 32'h0);
      repeat (2) @(posedge hdmi_clk);
      #3;
      reset   = 1'b0;
      fresh   = 1'b1;
      streak  = 0;
      hs_cnt  = 0;
      last_hs = ncyc;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0, 1'b0, 2'($urandom), 1'b0, 1'b0, 0, 0);
         if (i == 10) chk("wd_hold", 32'(locked), 32'(streak >= LF));
      end
      fresh  = 1'b1;
      streak = 0;
      chk("wd_unlock", 32'(locked), 32'h0);
   endtask

   initial begin
      ncyc = 0;
      m_h = 0; m_v = 0; m_ht = 0; m_vt = 0;
      #2;
      do_reset();
      new_params();
      // three clean frames: lock on the third frame_start
      repeat (3) send_frame(-1, 1'b0, -1, -1);
      // one short line, then two clean frames to relock
      send_frame($urandom_range(vact - 1, 1), 1'b0, -1, -1);
      repeat (2) send_frame(-1, 1'b0, -1, -1);
      // vsync coincident with the last active line's hsync
      repeat (3) send_frame(-1, 1'b1, -1, -1);
      // vsync stops: watchdog drops lock, no frame_start pulses
      idle((1 << TB) + 20);
      repeat (3) send_frame(-1, 1'b0, -1, -1);
      // reset in the middle of a line, stream restarts on a frame
      send_frame(-1, 1'b0, vact / 2, hact / 2);
      do_reset();
      repeat (3) send_frame(-1, 1'b0, -1, -1);
      // random timings, modes and damaged lines
      for (int k = 0; k < 6; k++) begin
         if ($urandom_range(2, 0) == 0) new_params();
         send_frame(($urandom_range(3, 0) == 0) ?
                    $urandom_range(vact - 1, 1) : -1,
                    1'($urandom), -1, -1);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tmds_video_timing.md
TMDS_VIDEO_TIMING -- requirements
Module: tmds_video_timing

Interface
REQ-001 SHALL have parameter XW, default 12, width of pixel/column counters.
REQ-002 SHALL have parameter YW, default 12, width of line counters.
REQ-003 SHALL have parameter LOCK_FRAMES, default 2, consecutive matching frames required to lock.
REQ-004 SHALL have parameter TIMEOUT_BITS, default 22, width of the frame watchdog counter.
REQ-005 SHALL have ports, one per line:
- hdmi_clk  in  1  pixel clock; all logic on its rising edge
- reset  in  1  asynchronous, active-high
- data_valid  in  1  channel 0 carries a pixel this cycle
- sync_valid  in  1  channel 0 carries a control word this cycle
- sync  in  2  control bits; [0]=hsync, [1]=vsync; meaningful only with sync_valid
- d0, d1, d2  in  8 each  decoded blue, green, red
- pix_valid  out  1  registered pixel strobe
- r, g, b  out  8 each  registered pixel (r=d2, g=d1, b=d0)
- x  out  XW  column of current pixel
- y  out  YW  line of current pixel
- frame_start  out  1  one-cycle pulse on vsync rising edge
- h_active  out  XW  measured active pixels per line
- v_active  out  YW  measured active lines per frame
- h_total, v_total  out  XW, YW  measured totals (see Configuration)
- locked  out  1  timing stable

Function
REQ-006 SHALL hold hs/vs registers updated from sync only when sync_valid=1; edges SHALL be detected on the held values.
REQ-007 SHALL register pixel outputs with 1-cycle latency: pix_valid, r, g, b, x, y SHALL reflect the inputs of the previous cycle.
REQ-008 SHALL increment column counter on each data_valid; x SHALL output the pre-increment value; the counter SHALL saturate at all-ones.
REQ-009 SHALL, on hs rising edge, reset the column counter to 0; if it was nonzero, increment the line counter (saturating) and record its value as the line width.
REQ-010 SHALL, on vs rising edge, load v_active with the line count, load h_active with the first line width of the frame, reset both counters, and pulse frame_start.
REQ-011 SHALL treat simultaneous hs and vs rising edges as hs processed first, then vs.
REQ-012 SHALL flag a frame mismatch if any line width within a frame differs from its first line width.
REQ-013 SHALL implement states UNLOCKED, MEASURE, LOCKED:
- UNLOCKED -> MEASURE on first vs rising edge, match count 0
- MEASURE: on vs edge, if h_active/v_active equal the previous frame and no mismatch, match count +1, else 0; -> LOCKED when count reaches LOCK_FRAMES
- LOCKED -> MEASURE on any mismatching frame
- any state -> UNLOCKED when watchdog reaches all-ones (2^TIMEOUT_BITS-1 cycles without vs edge)
REQ-014 SHALL assert locked only in LOCKED, and the same cycle as the frame_start that enters it.
REQ-015 SHALL clear the watchdog on every vs rising edge.

Reset
REQ-016 SHALL drive all outputs to 0, counters to 0, hs/vs to 0, state to UNLOCKED while reset is high, independent of hdmi_clk.
REQ-017 SHALL, on reset mid-frame, discard partial measurements; first subsequent vs edge enters MEASURE.

Configuration
REQ-018 SHALL, with TMDS_VIDEO_TIMING_TOTALS_EN defined, count every hdmi_clk cycle between hs rising edges into h_total and every hs rising edge between vs rising edges into v_total, updating at the respective edge and included in the lock comparison.
REQ-019 SHALL, without TMDS_VIDEO_TIMING_TOTALS_EN, keep h_total/v_total ports present and tied to 0, excluded from lock comparison.

Verification
REQ-020 640x480@800x525 stream, 3 frames -> h_active=640, v_active=480, locked=1 at third frame_start (totals build: h_total=800, v_total=525).
REQ-021 Pixel input d2=0x11,d1=0x22,d0=0x33 at column 5 line 7 -> next cycle pix_valid=1, r=0x11, g=0x22, b=0x33, x=5, y=7.
REQ-022 Locked, then one frame with line 100 of 639 pixels -> locked=0 at that frame_start; relocks after 2 clean frames.
REQ-023 Locked, then vs stops for 2^22 cycles -> locked=0, state UNLOCKED; no frame_start pulses.
REQ-024 reset asserted mid-line at x=300 -> all outputs 0 asynchronously; after release, first vs edge gives MEASURE, lock after LOCK_FRAMES further frames.
REQ-025 hs and vs rising same cycle after 480 lines -> v_active=480, y resets to 0, frame_start=1 one cycle.
